imem_byte_writer: RTL and testbench

Byte-serial store engine that is the write side of the byte-wide, little-endian program/data memory the core fetches from. It accepts one store request (byte, halfword or word) over a valid/ready handshake and emits it as consecutive single-byte writes, least significant byte at the lowest address. Alignment and range faults are rejected without touching memory. It sits between the loader/store path and the 8-bit memory array write port.

---
 rtl/imem_byte_writer.sv | 103 ++++++++++
 tb/tb_imem_byte_writer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_byte_writer.sv
// Byte-serial store engine: turns one byte/halfword/word store into consecutive
// little-endian single-byte writes, rejecting misaligned or out-of-range stores.
module imem_byte_writer #(
  parameter int unsigned MEM_BYTES = 131072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, data_q;
  logic [1:0]  idx_q, last_q;
  logic        err_q;

  logic        accept;
  logic        fault;
  logic [2:0]  nbytes;
  logic [2:0]  nbytes_m1;
  logic [32:0] end_addr;

  // Range check in 33 bits so a store near 4 GiB cannot wrap to a legal address.
  always_comb begin
    nbytes = 3'd4;
    case (req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    nbytes_m1 = nbytes - 3'd1;
    end_addr  = {1'b0, req_addr} + {30'b0, nbytes};
    fault     = (req_size == 2'b11)
             || ((req_size == 2'b01) && req_addr[0])
             || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
             || (end_addr > 33'(MEM_BYTES));
    accept    = req_valid && req_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fault ? RESP : WRITE;
      WRITE:   if (idx_q == last_q) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from state so reset drops the write strobe at once.
  always_comb begin
    req_ready  = (state == IDLE) && !rst;
    mem_we     = (state == WRITE);
    mem_addr   = 32'd0;
    mem_wdata  = 8'd0;
    resp_valid = (state == RESP);
    resp_err   = (state == RESP) && err_q;
    busy       = (state != IDLE);
    if (mem_we) begin
      mem_addr = addr_q + {30'b0, idx_q};
      case (idx_q)
        2'd0:    mem_wdata = data_q[7:0];
        2'd1:    mem_wdata = data_q[15:8];
        2'd2:    mem_wdata = data_q[23:16];
        default: mem_wdata = data_q[31:24];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= 32'd0;
      data_q <= 32'd0;
      idx_q  <= 2'd0;
      last_q <= 2'd0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= req_addr;
        data_q <= req_data;
        last_q <= nbytes_m1[1:0];
        err_q  <= fault;
        idx_q  <= 2'd0;
      end else if (state == WRITE) begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_byte_writer.sv
// Self-checking bench for imem_byte_writer: directed table, random stores against
// a plain-arithmetic model, back-to-back and reset-mid-write sequences.
module tb_imem_byte_writer;

  localparam int unsigned MEM = 131072;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic        busy;

  imem_byte_writer #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        exp_err;
    int          exp_n;
  } vec_t;

  vec_t        vecs[12];
  int          total = 0;
  int          fails = 0;
  logic [31:0] wa[8];
  logic [7:0]  wd[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         output logic err, output int nw, output int lat, output bit inv_ok);
    int k;
    nw = 0; lat = 0; err = 1'b0; inv_ok = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      // Scramble inputs after accept: the engine must have latched them.
      req_valid = 1'b0; req_addr = ~a; req_data = ~d; req_size = ~s;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        if (mem_we) begin
          if (nw < 8) begin
            wa[nw] = mem_addr;
            wd[nw] = mem_wdata;
          end
          nw++;
        end else if (mem_addr != 32'd0 || mem_wdata != 8'd0) begin
          inv_ok = 1'b0;
        end
        if (!resp_valid && resp_err) inv_ok = 1'b0;
        if (busy && req_ready) inv_ok = 1'b0;
        if (resp_valid) begin
          err = resp_err;
          lat = c;
          break;
        end
      end
    end
  endtask

  task automatic verify(input string name, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, input logic exp_err, input int exp_n);
    logic err;
    int   nw, lat;
    bit   inv_ok, bytes_ok;
    run_req(a, d, s, err, nw, lat, inv_ok);
    chk({name, "_err"}, 64'(err), 64'(exp_err));
    chk({name, "_lat"}, 64'(lat), 64'(exp_n + 1));
    chk({name, "_nwrites"}, 64'(nw), 64'(exp_n));
    bytes_ok = 1'b1;
    for (int j = 0; j < exp_n && j < 8; j++)
      if (wa[j] !== a + 32'(j) || wd[j] !== d[8*j +: 8]) bytes_ok = 1'b0;
    chk({name, "_bytes"}, 64'(bytes_ok), 64'd1);
    chk({name, "_idle_zero"}, 64'(inv_ok), 64'd1);
  endtask

  // Reference: a store of n bytes is legal iff naturally aligned and fully inside memory.
  function automatic void model(input logic [31:0] a, input logic [1:0] s,
                                output logic exp_err, output int exp_n);
    longint unsigned n, base;
    base = longint'({32'b0, a});
    if (s == 2'b11) begin
      exp_err = 1'b1;
    end else begin
      n = longint'(1) << s;
      exp_err = (base % n != 0) || (base + n > longint'(MEM));
    end
    exp_n = exp_err ? 0 : (1 << s);
  endfunction

  initial begin
    int   c, nacc, nres, nwb;
    int   acc_c[2], res_c[2], wc[8];
    logic [31:0] ba[8];
    logic [7:0]  bd[8];
    logic [31:0] b2b_a[8];
    logic [7:0]  b2b_d[8];
    bit   will, rdy_bad, ok, bad;
    logic [40:0] w0, w1;
    logic [31:0] ra, rd;
    logic [1:0]  rs;
    logic        e_err;
    int          e_n;

    vecs[0]  = '{"word_100",    32'h100,      32'hDEADBEEF, 2'b10, 1'b0, 4};
    vecs[1]  = '{"half_202",    32'h202,      32'h1234ABCD, 2'b01, 1'b0, 2};
    vecs[2]  = '{"byte_7",      32'h7,        32'h00000055, 2'b00, 1'b0, 1};
    vecs[3]  = '{"word_101",    32'h101,      32'hCAFEF00D, 2'b10, 1'b1, 0};
    vecs[4]  = '{"half_3",      32'h3,        32'h0000BEEF, 2'b01, 1'b1, 0};
    vecs[5]  = '{"size_11",     32'h40,       32'h01020304, 2'b11, 1'b1, 0};
    vecs[6]  = '{"word_1fffe",  32'h1FFFE,    32'h0BADCAFE, 2'b10, 1'b1, 0};
    vecs[7]  = '{"word_wrap",   32'hFFFFFFFC, 32'h13579BDF, 2'b10, 1'b1, 0};
    vecs[8]  = '{"byte_20000",  32'h20000,    32'h000000AA, 2'b00, 1'b1, 0};
    vecs[9]  = '{"word_1fffc",  32'h1FFFC,    32'h89ABCDEF, 2'b10, 1'b0, 4};
    vecs[10] = '{"byte_1ffff",  32'h1FFFF,    32'h000000C3, 2'b00, 1'b0, 1};
    vecs[11] = '{"half_1fffe",  32'h1FFFE,    32'h00007E81, 2'b01, 1'b0, 2};

    rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_data = 32'd0; req_size = 2'd0;
    #1;
    chk("reset_outputs", {23'd0, mem_we, mem_addr, mem_wdata, resp_valid, resp_err, busy, req_ready}, 64'd0);
    repeat (2) @(negedge clk);
    chk("reset_ready_low", 64'(req_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    for (int v = 0; v < 12; v++)
      verify(vecs[v].name, vecs[v].addr, vecs[v].data, vecs[v].size, vecs[v].exp_err, vecs[v].exp_n);

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'($urandom_range(0, 255));
        1:       ra = MEM - 8 + 32'($urandom_range(0, 15));
        2:       ra = $urandom;
        default: ra = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      endcase
      rd = $urandom;
      rs = 2'($urandom_range(0, 3));
      model(ra, rs, e_err, e_n);
      verify("rand", ra, rd, rs, e_err, e_n);
    end

    // Back-to-back words with req_valid held high across WRITE and RESP.
    nacc = 0; nres = 0; nwb = 0; will = 1'b0; rdy_bad = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h300; req_data = 32'hA1B2C3D4; req_size = 2'b10;
    for (c = 0; c < 20; c++) begin
      if (will) begin
        if (nacc == 1) begin
          req_addr = 32'h304; req_data = 32'h55667788;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (mem_we) begin
        if (nwb < 8) begin
          ba[nwb] = mem_addr; bd[nwb] = mem_wdata; wc[nwb] = c;
        end
        nwb++;
      end
      if (resp_valid) begin
        if (nres < 2) res_c[nres] = c;
        nres++;
      end
      if (busy && req_ready) rdy_bad = 1'b1;
      will = req_valid && req_ready;
      if (will) begin
        if (nacc < 2) acc_c[nacc] = c;
        nacc++;
      end
      @(negedge clk);
    end
    chk("b2b_accepts", 64'(nacc), 64'd2);
    chk("b2b_resps", 64'(nres), 64'd2);
    chk("b2b_writes", 64'(nwb), 64'd8);
    chk("b2b_ready_low_busy", 64'(rdy_bad), 64'd0);
    if (nacc == 2 && nres == 2 && nwb == 8) begin
      chk("b2b_second_accept", 64'(acc_c[1]), 64'(res_c[0] + 1));
      chk("b2b_period", 64'(acc_c[1] - acc_c[0]), 64'd6);
      chk("b2b_first_b_write", 64'(wc[4]), 64'(acc_c[1] + 1));
      b2b_a = '{32'h300, 32'h301, 32'h302, 32'h303, 32'h304, 32'h305, 32'h306, 32'h307};
      b2b_d = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h88, 8'h77, 8'h66, 8'h55};
      ok = 1'b1;
      for (int j = 0; j < 8; j++) begin
        if (ba[j] !== b2b_a[j] || bd[j] !== b2b_d[j]) ok = 1'b0;
        if (wc[j] !== ((j < 4) ? acc_c[0] + 1 + j : acc_c[1] + 1 + (j - 4))) ok = 1'b0;
      end
      chk("b2b_bytes_order", 64'(ok), 64'd1);
    end

    // Reset during the third byte of a word store.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h40; req_data = 32'h11223344; req_size = 2'b10;
    c = 0;
    while (!req_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    w0 = {mem_we, mem_addr, mem_wdata};
    @(negedge clk);
    w1 = {mem_we, mem_addr, mem_wdata};
    chk("rst_mid_byte0", 64'(w0), {23'd0, 1'b1, 32'h40, 8'h44});
    chk("rst_mid_byte1", 64'(w1), {23'd0, 1'b1, 32'h41, 8'h33});
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_we_drop", {61'd0, mem_we, busy, req_ready}, 64'd0);
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_we || resp_valid) bad = 1'b1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_we || resp_valid) bad = 1'b1;
    end
    chk("rst_mid_no_activity", 64'(bad), 64'd0);
    chk("rst_mid_ready_after", 64'(req_ready), 64'd1);
    verify("after_rst_word", 32'h80, 32'h0F1E2D3C, 2'b10, 1'b0, 4);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
